// File: rtl/uart_frame_ctrl_if.sv
// Byte-stream and frame-buffer signals between the UART receive path, the frame controller and its consumer.
// The master drives the receive strobes, read address and ack. The slave is the frame controller.
interface uart_frame_ctrl_if #(
  parameter int MAX_LEN = 16
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ferr;
  logic          frm_valid;
  logic [LW-1:0] frm_len;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          frm_ack;
  logic          err_pulse;
  logic [2:0]    err_code;
  logic          busy;

  modport master (
    output rx_valid, rx_data, rx_ferr, rd_addr, frm_ack,
    input  frm_valid, frm_len, rd_data, err_pulse, err_code, busy
  );

  modport slave (
    input  rx_valid, rx_data, rx_ferr, rd_addr, frm_ack,
    output frm_valid, frm_len, rd_data, err_pulse, err_code, busy
  );
endinterface

// File: rtl/uart_frame_ctrl.sv
// Assembles SYNC/LEN/payload/CHK byte frames into a held buffer. Status appears 1 clk after the strobing byte, and rd_data has 1 clk latency.
// There is no backpressure on rx: bytes that arrive while a frame is held are dropped with an overrun error until frm_ack.
module uart_frame_ctrl #(
  parameter int         MAX_LEN   = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              reset,
  uart_frame_ctrl_if.slave  bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  localparam logic [2:0] E_LEN = 3'd1;
  localparam logic [2:0] E_CHK = 3'd2;
  localparam logic [2:0] E_FRM = 3'd3;
  localparam logic [2:0] E_TMO = 3'd4;
  localparam logic [2:0] E_OVR = 3'd5;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]    LEN_MAX8 = 8'(MAX_LEN);

  logic [2:0]    state;
  logic [LW-1:0] len;
  logic [AW-1:0] idx;
  logic [7:0]    chk;
  logic [TW-1:0] tcnt;
  logic [7:0]    buffer [MAX_LEN];
  logic          in_frame;
  logic          buf_we;

  assign in_frame = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
  assign buf_we   = (state == S_DATA) && bus.rx_valid && !bus.rx_ferr;
  assign bus.busy = (state != S_IDLE);

  // The buffer has no reset so it can map onto plain RAM. Writes happen only in DATA, which keeps it frozen in HOLD.
  always_ff @(posedge clk) begin
    if (buf_we) buffer[idx] <= bus.rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) bus.rd_data <= 8'h00;
    else       bus.rd_data <= buffer[bus.rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      len           <= '0;
      idx           <= '0;
      chk           <= 8'h00;
      tcnt          <= '0;
      bus.frm_valid <= 1'b0;
      bus.frm_len   <= '0;
      bus.err_pulse <= 1'b0;
      bus.err_code  <= 3'd0;
    end else begin
      bus.err_pulse <= 1'b0;

      if (!in_frame || bus.rx_valid) tcnt <= '0;
      else                           tcnt <= tcnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (bus.rx_valid && !bus.rx_ferr && bus.rx_data == SYNC_BYTE)
            state <= S_LEN;
        end

        S_LEN, S_DATA, S_CHK: begin
          // A framing error wins over any content check on the same byte.
          if (bus.rx_valid && bus.rx_ferr) begin
            bus.err_pulse <= 1'b1;
            bus.err_code  <= E_FRM;
            state         <= S_IDLE;
          end else if (!bus.rx_valid && tcnt == TMO_LAST) begin
            bus.err_pulse <= 1'b1;
            bus.err_code  <= E_TMO;
            state         <= S_IDLE;
          end else if (bus.rx_valid) begin
            if (state == S_LEN) begin
              if (bus.rx_data == 8'h00 || bus.rx_data > LEN_MAX8) begin
                bus.err_pulse <= 1'b1;
                bus.err_code  <= E_LEN;
                state         <= S_IDLE;
              end else begin
                len   <= bus.rx_data[LW-1:0];
                chk   <= bus.rx_data;
                idx   <= '0;
                state <= S_DATA;
              end
            end else if (state == S_DATA) begin
              chk <= chk ^ bus.rx_data;
              idx <= idx + 1'b1;
              if (LW'(idx) == len - 1'b1) state <= S_CHK;
            end else begin
              if (bus.rx_data == chk) begin
                bus.frm_valid <= 1'b1;
                bus.frm_len   <= len;
                state         <= S_HOLD;
              end else begin
                bus.err_pulse <= 1'b1;
                bus.err_code  <= E_CHK;
                state         <= S_IDLE;
              end
            end
          end
        end

        S_HOLD: begin
          if (bus.rx_valid) begin
            bus.err_pulse <= 1'b1;
            bus.err_code  <= E_OVR;
          end
          if (bus.frm_ack) begin
            bus.frm_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Scoreboard bench for uart_frame_ctrl: expected error/frame events are queued as bytes are driven and matched against monitored DUT events.
module tb_uart_frame_ctrl;
  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  // Event encoding: 100+err_code for an error pulse, 200+frm_len for a newly held frame.
  int   exp_ev[$];
  int   obs_ev[$];
  logic [7:0] pl [MAX_LEN];
  logic prev_fv = 1'b0;

  uart_frame_ctrl_if #(.MAX_LEN(MAX_LEN)) bus();

  uart_frame_ctrl #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(8'hA5), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.err_pulse) obs_ev.push_back(100 + int'(bus.err_code));
      if (bus.frm_valid && !prev_fv) obs_ev.push_back(200 + int'(bus.frm_len));
    end
    prev_fv = bus.frm_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 2000000", $time);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] d, input logic f);
    bus.rx_valid = 1'b1;
    bus.rx_data  = d;
    bus.rx_ferr  = f;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_ferr  = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] flip);
    logic [7:0] c;
    c = 8'(n);
    send_byte(8'hA5, 1'b0);
    send_byte(8'(n), 1'b0);
    for (int i = 0; i < n; i++) begin
      c = c ^ pl[i];
      send_byte(pl[i], 1'b0);
    end
    send_byte(c ^ flip, 1'b0);
  endtask

  task automatic ack_frame();
    bus.frm_ack = 1'b1;
    @(negedge clk);
    bus.frm_ack = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (bus.frm_valid !== 1'b0) begin n_fail++; $display("FAIL rst_frm_valid: got %b, expected 0", bus.frm_valid); end
    n_chk++; if (bus.frm_len !== 5'd0) begin n_fail++; $display("FAIL rst_frm_len: got %0d, expected 0", bus.frm_len); end
    n_chk++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL rst_rd_data: got %h, expected 00", bus.rd_data); end
    n_chk++; if (bus.err_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_err_pulse: got %b, expected 0", bus.err_pulse); end
    n_chk++; if (bus.err_code !== 3'd0) begin n_fail++; $display("FAIL rst_err_code: got %0d, expected 0", bus.err_code); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, expected 0", bus.busy); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    int e, o;
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    exp_ev.push_back(203);
    send_frame(3, 8'h00);
    n_chk++; if (bus.frm_valid !== 1'b1) begin n_fail++; $display("FAIL basic_frm_valid: got %b, expected 1", bus.frm_valid); end
    n_chk++; if (bus.frm_len !== 5'd3) begin n_fail++; $display("FAIL basic_frm_len: got %0d, expected 3", bus.frm_len); end
    n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_hold: got %b, expected 1", bus.busy); end
    for (int i = 0; i < 3; i++) begin
      bus.rd_addr = 4'(i);
      @(negedge clk);
      n_chk++; if (bus.rd_data !== pl[i]) begin n_fail++; $display("FAIL basic_rd[%0d]: got %h, expected %h", i, bus.rd_data, pl[i]); end
    end
    ack_frame();
    n_chk++; if (bus.frm_valid !== 1'b0) begin n_fail++; $display("FAIL basic_ack_valid: got %b, expected 0", bus.frm_valid); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_ack_busy: got %b, expected 0", bus.busy); end
    repeat (2) @(negedge clk);
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front(); o = (obs_ev.size() > 0) ? obs_ev.pop_front() : -1;
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL basic_event: got %0d, expected %0d", o, e); end
    end
    n_chk++; if (obs_ev.size() != 0) begin n_fail++; $display("FAIL basic_extra: got %0d extra events (first %0d), expected 0", obs_ev.size(), obs_ev[0]); obs_ev.delete(); end
  endtask

  task automatic test_bad_chk();
    int e, o;
    pl[0] = 8'h10; pl[1] = 8'h20;
    exp_ev.push_back(102);
    send_frame(2, 8'h03);
    @(negedge clk);
    n_chk++; if (bus.frm_valid !== 1'b0) begin n_fail++; $display("FAIL chk_frm_valid: got %b, expected 0", bus.frm_valid); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL chk_busy: got %b, expected 0", bus.busy); end
    n_chk++; if (bus.err_code !== 3'd2) begin n_fail++; $display("FAIL chk_err_code: got %0d, expected 2", bus.err_code); end
    repeat (2) @(negedge clk);
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front(); o = (obs_ev.size() > 0) ? obs_ev.pop_front() : -1;
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL chk_event: got %0d, expected %0d", o, e); end
    end
    n_chk++; if (obs_ev.size() != 0) begin n_fail++; $display("FAIL chk_extra: got %0d extra events (first %0d), expected 0", obs_ev.size(), obs_ev[0]); obs_ev.delete(); end
  endtask

  task automatic test_len_bounds();
    int e, o;
    exp_ev.push_back(101);
    send_byte(8'hA5, 1'b0); send_byte(8'h00, 1'b0);
    exp_ev.push_back(101);
    send_byte(8'hA5, 1'b0); send_byte(8'h11, 1'b0);
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL len_busy: got %b, expected 0", bus.busy); end
    for (int i = 0; i < MAX_LEN; i++) pl[i] = 8'(i * 7 + 3);
    exp_ev.push_back(216);
    send_frame(MAX_LEN, 8'h00);
    n_chk++; if (bus.frm_len !== 5'd16) begin n_fail++; $display("FAIL len_max_frm_len: got %0d, expected 16", bus.frm_len); end
    for (int i = 0; i < MAX_LEN; i++) begin
      bus.rd_addr = 4'(i);
      @(negedge clk);
      n_chk++; if (bus.rd_data !== pl[i]) begin n_fail++; $display("FAIL len_rd[%0d]: got %h, expected %h", i, bus.rd_data, pl[i]); end
    end
    ack_frame();
    repeat (2) @(negedge clk);
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front(); o = (obs_ev.size() > 0) ? obs_ev.pop_front() : -1;
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL len_event: got %0d, expected %0d", o, e); end
    end
    n_chk++; if (obs_ev.size() != 0) begin n_fail++; $display("FAIL len_extra: got %0d extra events (first %0d), expected 0", obs_ev.size(), obs_ev[0]); obs_ev.delete(); end
  endtask

  task automatic test_timeout();
    int e, o;
    send_byte(8'hA5, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h44, 1'b0);
    repeat (TIMEOUT - 5) @(negedge clk);
    n_chk++; if (obs_ev.size() != 0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL tmo_early: got %0d events busy=%b, expected 0 events busy=1", obs_ev.size(), bus.busy); end
    exp_ev.push_back(104);
    repeat (10) @(negedge clk);
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy: got %b, expected 0", bus.busy); end
    pl[0] = 8'h7E;
    exp_ev.push_back(201);
    send_frame(1, 8'h00);
    bus.rd_addr = 4'd0;
    @(negedge clk);
    n_chk++; if (bus.rd_data !== 8'h7E) begin n_fail++; $display("FAIL tmo_rd0: got %h, expected 7e", bus.rd_data); end
    ack_frame();
    repeat (2) @(negedge clk);
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front(); o = (obs_ev.size() > 0) ? obs_ev.pop_front() : -1;
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL tmo_event: got %0d, expected %0d", o, e); end
    end
    n_chk++; if (obs_ev.size() != 0) begin n_fail++; $display("FAIL tmo_extra: got %0d extra events (first %0d), expected 0", obs_ev.size(), obs_ev[0]); obs_ev.delete(); end
  endtask

  task automatic test_overrun();
    int e, o;
    pl[0] = 8'hC3; pl[1] = 8'h3C;
    exp_ev.push_back(202);
    send_frame(2, 8'h00);
    repeat (4) exp_ev.push_back(105);
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h55, 1'b0); send_byte(8'h54, 1'b0);
    n_chk++; if (bus.frm_valid !== 1'b1 || bus.frm_len !== 5'd2) begin n_fail++; $display("FAIL ovr_hold: got valid=%b len=%0d, expected valid=1 len=2", bus.frm_valid, bus.frm_len); end
    for (int i = 0; i < 2; i++) begin
      bus.rd_addr = 4'(i);
      @(negedge clk);
      n_chk++; if (bus.rd_data !== pl[i]) begin n_fail++; $display("FAIL ovr_rd[%0d]: got %h, expected %h", i, bus.rd_data, pl[i]); end
    end
    // ack and a byte in the same cycle: byte dropped with overrun, and it does not start a frame
    exp_ev.push_back(105);
    bus.frm_ack = 1'b1;
    send_byte(8'hA5, 1'b0);
    bus.frm_ack = 1'b0;
    send_byte(8'h01, 1'b0); send_byte(8'h55, 1'b0); send_byte(8'h54, 1'b0);
    n_chk++; if (bus.frm_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL ovr_release: got valid=%b busy=%b, expected 0 0", bus.frm_valid, bus.busy); end
    pl[0] = 8'h55;
    exp_ev.push_back(201);
    send_frame(1, 8'h00);
    bus.rd_addr = 4'd0;
    @(negedge clk);
    n_chk++; if (bus.rd_data !== 8'h55) begin n_fail++; $display("FAIL ovr_resend_rd0: got %h, expected 55", bus.rd_data); end
    ack_frame();
    repeat (2) @(negedge clk);
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front(); o = (obs_ev.size() > 0) ? obs_ev.pop_front() : -1;
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL ovr_event: got %0d, expected %0d", o, e); end
    end
    n_chk++; if (obs_ev.size() != 0) begin n_fail++; $display("FAIL ovr_extra: got %0d extra events (first %0d), expected 0", obs_ev.size(), obs_ev[0]); obs_ev.delete(); end
  endtask

  task automatic test_ferr_and_reset();
    int e, o;
    send_byte(8'h00, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'h13, 1'b0);
    send_byte(8'hA5, 1'b1);
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ferr_garbage_busy: got %b, expected 0", bus.busy); end
    exp_ev.push_back(103);
    send_byte(8'hA5, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b1);
    n_chk++; if (bus.err_code !== 3'd3 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL ferr_code: got code=%0d busy=%b, expected 3 0", bus.err_code, bus.busy); end
    repeat (2) @(negedge clk);
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front(); o = (obs_ev.size() > 0) ? obs_ev.pop_front() : -1;
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL ferr_event: got %0d, expected %0d", o, e); end
    end
    send_byte(8'hA5, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.busy !== 1'b0 || bus.frm_valid !== 1'b0 || bus.frm_len !== 5'd0) begin n_fail++; $display("FAIL mid_rst_state: got busy=%b valid=%b len=%0d, expected 0 0 0", bus.busy, bus.frm_valid, bus.frm_len); end
    n_chk++; if (bus.err_code !== 3'd0 || bus.err_pulse !== 1'b0 || bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_out: got code=%0d pulse=%b rd=%h, expected 0 0 00", bus.err_code, bus.err_pulse, bus.rd_data); end
    reset = 1'b0;
    pl[0] = 8'h00;
    exp_ev.push_back(201);
    send_frame(1, 8'h00);
    ack_frame();
    repeat (2) @(negedge clk);
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front(); o = (obs_ev.size() > 0) ? obs_ev.pop_front() : -1;
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL rst_recover_event: got %0d, expected %0d", o, e); end
    end
    n_chk++; if (obs_ev.size() != 0) begin n_fail++; $display("FAIL ferr_extra: got %0d extra events (first %0d), expected 0", obs_ev.size(), obs_ev[0]); obs_ev.delete(); end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_ferr  = 1'b0;
    bus.rd_addr  = '0;
    bus.frm_ack  = 1'b0;
    test_reset();
    test_basic_frame();
    test_bad_chk();
    test_len_bounds();
    test_timeout();
    test_overrun();
    test_ferr_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
